// File: rtl/od_arb_pkg.sv
// Shared encodings and width helper for the open-drain bus arbiter.
package od_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN      = 2'd1,
    TURN     = 2'd2,
    WAIT_REL = 2'd3
  } arb_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/od_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to bit 0.
module rr_pick
  import od_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               vld_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick_src;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) hi_mask[i] = (PW'(i) >= ptr_i);
  end

  // Prefer requesters at/above the pointer; fall back to the wrapped set.
  assign masked   = req_i & hi_mask;
  assign pick_src = (|masked) ? masked : req_i;
  assign win_o    = pick_src & (-pick_src);
  assign vld_o    = |req_i;

endmodule

// File: rtl/od_bus_arbiter.sv
// Round-robin owner of one open-drain wired line with hold limit, turnaround and stuck-line detection.
module od_bus_arbiter
  import od_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8,
  parameter int TURN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dat,
  input  logic               bus_sense,
  output logic               bus_a,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               stuck
);

  localparam int PW = clog2_min1(NUM_REQ);
  localparam int HW = clog2_min1(HOLD_MAX);
  localparam int TW = clog2_min1(TURN_CYC);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      turn_q, turn_d;
  logic               busy_q, busy_d;
  logic               stuck_q, stuck_d;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_vld;
  logic [PW-1:0]      own_idx;
  logic [PW-1:0]      nxt_ptr;
  logic               own_req;
  logic               own_dat;
  logic               hold_end;
  logic               turn_end;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) own_idx = PW'(i);
  end

  assign nxt_ptr  = (own_idx == PW'(NUM_REQ-1)) ? '0 : own_idx + PW'(1);
  assign own_req  = |(req & grant_q);
  assign own_dat  = |(dat & grant_q);
  assign hold_end = (hold_q == HW'(HOLD_MAX-1));
  assign turn_end = (turn_q == TW'(TURN_CYC-1));

  // Only the owner's data reaches the buffer; every other state releases the line.
  assign bus_a = (state_q == OWN) ? own_dat : 1'b1;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign stuck = stuck_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          if (bus_sense) begin
            state_d = OWN;
            grant_d = pick_win;
            hold_d  = '0;
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      OWN: begin
        // Counters stop at their terminal value so they never wrap.
        if (!own_req || hold_end) begin
          state_d  = TURN;
          grant_d  = '0;
          turn_d   = '0;
          rr_ptr_d = nxt_ptr;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_end) state_d = bus_sense ? IDLE : WAIT_REL;
        else          turn_d  = turn_q + TW'(1);
      end
      WAIT_REL: begin
        if (bus_sense) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    stuck_d = (state_d == WAIT_REL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      busy_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
      stuck_q  <= stuck_d;
    end
  end

endmodule

// File: tb/tb_od_bus_arbiter.sv
// Directed bench: grant events are queued as expectations and a negedge monitor checks owner, length and gap.
module tb_od_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] dat = 4'b1111;
  logic       ext_n = 1'b1;
  logic       bus_sense, bus_a, busy, stuck;
  logic [3:0] grant;

  assign bus_sense = bus_a & ext_n;

  always #5 clk = ~clk;

  od_bus_arbiter #(.NUM_REQ(4), .HOLD_MAX(8), .TURN_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dat       (dat),
    .bus_sense (bus_sense),
    .bus_a     (bus_a),
    .grant     (grant),
    .busy      (busy),
    .stuck     (stuck)
  );

  typedef struct {
    logic [3:0] g;
    int         len;  // owned cycles, 0 = not checked
    int         gap;  // idle cycles before grant, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input int len, input int gap);
    exp_t e;
    e.g = g; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 40) begin
      tick();
      i++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: each new grant pops one expectation.
  initial begin
    exp_t       cur;
    logic [3:0] prev = 4'b0000;
    int         run = 0;
    int         gap = 0;
    cur.g = 4'b0000; cur.len = 0; cur.gap = -1;
    forever begin
      @(negedge clk);
      if (grant != 4'b0000 && prev == 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("sb_grant", 32'(grant), 32'(cur.g));
          if (cur.gap >= 0) chk("sb_gap", gap, cur.gap);
        end
        run = 1;
      end else if (grant != 4'b0000 && grant == prev) begin
        run++;
      end else if (grant != 4'b0000) begin
        chk("grant_switch_without_gap", 32'(grant), 32'(prev));
        run = 1;
      end else if (prev != 4'b0000) begin
        if (cur.len > 0) chk("sb_len", run, cur.len);
        gap = 1;
      end else begin
        gap++;
      end
      prev = grant;
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bus_a", 32'(bus_a), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_stuck", 32'(stuck), 32'd0);

    // Reset asserted mid-ownership
    @(negedge clk);
    rst = 1'b0; req = 4'b0010; dat = 4'b0000;
    push(4'b0010, 0, -1);
    tick();
    chk("own_grant", 32'(grant), 32'h2);
    chk("own_bus_a", 32'(bus_a), 32'd0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_bus_a", 32'(bus_a), 32'd1);
    chk("midrst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(4'b0010, 1, -1);
    tick();
    chk("postrst_grant", 32'(grant), 32'h2);
    req = 4'b0000;  // withdrawn in first grant cycle -> 1 owned cycle
    wait_idle();

    // Single requester, hold limit then re-grant
    req = 4'b0100; dat = 4'b0000;
    push(4'b0100, 8, -1);
    push(4'b0100, 8, 3);
    tick();
    chk("single_bus_a_low", 32'(bus_a), 32'd0);
    repeat (8) tick();
    chk("single_turn_grant", 32'(grant), 32'd0);
    chk("single_turn_bus_a", 32'(bus_a), 32'd1);
    chk("single_turn_busy",  32'(busy),  32'd1);
    repeat (11) tick();
    req = 4'b0000;
    wait_idle();

    // All requesting from rr_ptr=0
    rst = 1'b1;
    #2;
    chk("rst2_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req = 4'b1111; dat = 4'b1111;
    push(4'b0001, 8, -1);
    push(4'b0010, 8, 3);
    push(4'b0100, 8, 3);
    push(4'b1000, 8, 3);
    push(4'b0001, 8, 3);
    tick();
    repeat (52) tick();
    req = 4'b0000;
    wait_idle();

    // Early release; pointer moves past owner 0
    req = 4'b0001; dat = 4'b0000;
    push(4'b0001, 3, -1);
    tick(); tick(); tick();
    req = 4'b1000;
    tick();
    chk("early_turn_grant", 32'(grant), 32'd0);
    chk("early_turn_busy",  32'(busy),  32'd1);
    req = 4'b1001;
    push(4'b1000, 1, 3);
    tick(); tick(); tick();
    chk("rr_grant_3", 32'(grant), 32'h8);

    // External holder during TURN
    req = 4'b0001;
    push(4'b0001, 5, 6);
    tick();
    ext_n = 1'b0;
    chk("ext_turn_grant", 32'(grant), 32'd0);
    tick(); tick();
    chk("wait_stuck", 32'(stuck), 32'd1);
    chk("wait_grant", 32'(grant), 32'd0);
    tick(); tick();
    chk("wait_stuck2", 32'(stuck), 32'd1);
    chk("wait_busy",   32'(busy),  32'd1);
    chk("wait_grant2", 32'(grant), 32'd0);
    ext_n = 1'b1;
    tick();
    chk("rel_stuck", 32'(stuck), 32'd0);
    chk("rel_busy",  32'(busy),  32'd0);
    chk("rel_grant", 32'(grant), 32'd0);
    tick();
    chk("rel_regrant", 32'(grant), 32'h1);

    // Owner data follows through; non-owner data ignored
    for (int k = 0; k < 4; k++) begin
      dat[0] = k[0];
      #1;
      chk("dat_follow", 32'(bus_a), 32'(k[0]));
      dat[2] = ~dat[2];
      #1;
      chk("dat_nonowner", 32'(bus_a), 32'(k[0]));
      tick();
    end
    req = 4'b0000;
    wait_idle();
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/od_bus_arbiter.md
Name: od_bus_arbiter

Overview:
- Shares one open-drain wired line between NUM_REQ requesters. The line is driven through a single od_buf channel of a 74LVC07-style hex open-drain buffer.
- Round-robin arbitration gives at most one requester ownership at a time.
- Each ownership is bounded by a maximum hold time.
- After every ownership the line is released for a turnaround period, giving the pull-up time to recover.
- The block reads the line back and refuses to grant while something outside the arbiter holds it low.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_MAX, 8, maximum consecutive cycles one requester owns the line (>=1).
- TURN_CYC, 2, released-line cycles after each ownership (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester bus request; level, held while the line is wanted.
- dat  input  NUM_REQ  per-requester data bit; 0 = pull line low, 1 = release.
- bus_sense  input  1  read-back of the wired line after pull-up (1 = high/idle).
- bus_a  output  1  drive to od_buf input; 0 pulls line low, 1 releases.
- grant  output  NUM_REQ  one-hot current owner; all-zero when nobody owns.
- busy  output  1  high in any state other than IDLE.
- stuck  output  1  high while waiting for an external holder to release the line.

Behaviour:
- Reset (async, immediate):
  - grant=0, bus_a=1, busy=0, stuck=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0, turn_cnt=0.
  - Reset asserted mid-ownership drops grant and releases the line without waiting for a clock edge.
- State is one of IDLE, OWN, TURN, WAIT_REL. All outputs are registered. bus_a is the only output that follows dat combinationally, and only while in OWN.
- IDLE:
  - bus_a=1.
  - If req!=0 and bus_sense==1: pick the first set req bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). Next edge: grant=onehot(winner), state=OWN, hold_cnt=0. Grant latency is 1 cycle from req.
  - If req!=0 and bus_sense==0: state=WAIT_REL, no grant.
- OWN:
  - bus_a = dat[owner]; hold_cnt increments each cycle.
  - Exit to TURN on the edge where req[owner]==0 or hold_cnt==HOLD_MAX-1.
  - On that edge: grant=0, bus_a=1, turn_cnt=0, rr_ptr=(owner+1) mod NUM_REQ.
  - Ownership therefore lasts 1..HOLD_MAX cycles. A req withdrawn in the first grant cycle still yields exactly 1 owned cycle.
  - Other requesters' req/dat changes are ignored during OWN.
- TURN:
  - bus_a=1, grant=0; turn_cnt increments.
  - When turn_cnt==TURN_CYC-1: next state IDLE if bus_sense==1, else WAIT_REL.
  - A new grant is never issued in the same cycle TURN ends; minimum gap between grants is TURN_CYC+1 cycles.
- WAIT_REL:
  - stuck=1, bus_a=1, grant=0.
  - Return to IDLE on the first edge with bus_sense==1; stuck clears on that edge.
  - No timeout.
- Counters are sized $clog2(HOLD_MAX)/$clog2(TURN_CYC), minimum 1 bit. hold_cnt and turn_cnt never wrap, because exit is forced at the terminal value.
- Fairness: after a full sweep with all req held, every requester has been granted once. A requester cannot win twice in a row while another req is set.

Decomposition:
- Shared package/include od_arb_pkg holds the state encoding constants (IDLE=2'd0, OWN=2'd1, TURN=2'd2, WAIT_REL=2'd3) and a clog2-min-1 width helper.
- One sub-module, rr_pick: purely combinational round-robin picker. Inputs are req and rr_ptr; outputs are a one-hot winner and a valid flag.
- The FSM, counters, rr_ptr and output registers stay in od_bus_arbiter.
- The od_buf instance lives outside the block, in the board-level netlist.

Test Plan (NUM_REQ=4, HOLD_MAX=8, TURN_CYC=2, bus_sense modelled as AND of bus_a and external pull-down):
- Reset mid-OWN with grant=4'b0010, bus_a=0: assert rst between edges -> grant=0, bus_a=1, busy=0 immediately. After release, req=4'b0010 -> grant=4'b0010 one cycle later.
- Single requester: req=4'b0100 held, dat=0 -> grant=4'b0100 for exactly 8 cycles with bus_a=0, then 2 TURN cycles with bus_a=1, then re-grant to 4'b0100.
- All req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001. Each lasts 8 cycles, separated by 3 cycles with grant=0.
- Early release: req0 granted, deassert req0 after 3 owned cycles -> TURN starts on the next edge. rr_ptr=1, so pending req=4'b1001 grants 4'b1000.
- External holder: force line low during TURN -> WAIT_REL with stuck=1 and no grant despite req=4'b0001. Release the line -> stuck=0 and IDLE on the next edge, grant=4'b0001 one cycle after that.
- dat follow-through: during OWN toggle dat[owner] 0/1 each cycle -> bus_a mirrors it combinationally. Toggling a non-owner's dat has no effect on bus_a.
